y_seq_ctrl: RTL
===============

# y_seq_ctrl

Multi-cycle sequencer for the yIF/yID/yEX/yDM/yWB datapath. It replaces hand-driven control with an FSM that owns the PC and decodes the fetched instruction. It drives RegWrite, ALUSrc, ALU op, memory strobes and write-back select, so each instruction retires in 3–5 cycles and each write strobe is asserted on exactly one clock edge. It sits beside the datapath in the lab top level, feeding PCin and consuming ins, zero, PCp4, branch and jTarget.

## Interface
- RESET_PC, 32'h28: PC value loaded on reset.
- MAX_INS, 0: retire budget before auto-halt; 0 = unlimited.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- run  in  1  permit to start a new instruction; sampled in IDLE only
- ins  in  32  instruction from yIF
- zero  in  1  ALU zero flag from yEX
- PCp4, branch, jTarget  in  32 each  next-PC candidates from yIF/yID
- PCin  out  32  PC register, to yIF
- RegWrite, ALUSrc, MemRead, MemWrite  out  1 each  datapath controls
- op  out  3  ALU op: 010 add, 110 sub, 000 and, 001 or, 111 slt
- wbSel  out  2  write-back source: 00 ALU z, 01 memOut, 10 PCp4
- halted  out  1  FSM in HALT
- illegal  out  1  sticky; set on unsupported opcode
- retired  out  32  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE→FETCH when run=1, otherwise stay in IDLE. At FETCH→DECODE, ins is captured into an internal IR, and all decode uses IR from then on.
- DECODE→EXEC for legal opcodes. Any other opcode goes to HALT, sets illegal, and leaves PC unchanged.
- Legal opcodes, with the path after EXEC:
  - 0x33 R-type: EXEC→WB, ALUSrc=0.
  - 0x13 I-type ALU: EXEC→WB.
  - 0x03 load: EXEC→MEM→WB.
  - 0x23 store: EXEC→MEM.
  - 0x63 beq: ends in EXEC.
  - 0x6F jal: EXEC→WB with wbSel=10.
- ALUSrc=1 for all opcodes except 0x33 and 0x63.
- ALU op:
  - R-type and 0x13 decode funct3: 000→add, or sub if funct7[5] on R-type; 111→and; 110→or; 010→slt. Any other funct3 is illegal.
  - Load, store and jal use add. Beq uses sub.
- MemRead=1 only in MEM of a load. MemWrite=1 only in MEM of a store.
- RegWrite=1 only in WB. wbSel=01 for loads and 10 for jal.
- Final state of each instruction: PCin updates at the closing edge and retired increments.
  - beq: PCin←branch if zero, else PCp4.
  - jal: PCin←jTarget.
  - All others: PCin←PCp4.
- After the final state, the FSM goes to IDLE, or to HALT if MAX_INS≠0 and retired+1 == MAX_INS.
- HALT is absorbing. Only reset leaves it.
- All control outputs are 0 in IDLE, FETCH, DECODE and HALT. op holds its decoded value from EXEC through the final state.

## Timing
- Reset, effective at the first clock edge with reset=1:
  - State IDLE, PCin=RESET_PC, retired=0, illegal=0.
  - All strobes 0.
  - Reset overrides every state, including MEM and WB mid-instruction, and drops the pending write.
- Cycles from IDLE exit to retire: beq 3 (FETCH, DECODE, EXEC). R-type, I-type, store and jal take 4. Load takes 5. IDLE adds 1 cycle per instruction.
- PCin is stable from FETCH through the final state, so ins stays stable for the datapath.
- All outputs are registered state decode. There is no combinational path from run to any output.
- retired wraps modulo 2^32. The MAX_INS compare uses the pre-increment value.

## Structure
- Shared package y_ctrl_pkg holds:
  - the state enum;
  - opcode constants OP_R, OP_I, OP_LD, OP_ST, OP_BEQ, OP_JAL;
  - ALU op constants;
  - wbSel constants.
- One sub-module, y_ctrl_decode: combinational IR→{legal, ALUSrc, op, wbSel, class}.
- Everything else (FSM, PC register, counter) stays in y_seq_ctrl.

## Test plan
- Reset mid-stream: assert reset in MEM of a store → MemWrite=0 on that edge, PCin=0x28, retired=0, state IDLE.
- add x3,x1,x2 (0x002081B3) with run=1 → RegWrite high only in cycle 4, op=010, ALUSrc=0, PCin=0x2C after cycle 4, retired=1.
- Load 0x0000A183 → MemRead high only in cycle 4, RegWrite with wbSel=01 in cycle 5, op=010.
- beq taken (zero=1, branch=0x40) → op=110, 3 cycles, PCin=0x40. Same with zero=0 → PCin=PCp4.
- Opcode 0x7F at PC 0x30 → halted=1, illegal=1, PCin stays 0x30, no strobes, run ignored until reset.
- MAX_INS=3, three I-type instructions → halted after the third retire, retired=3, PCin=0x34.

Source files
------------

// File: rtl/y_ctrl_pkg.sv
// Shared types and constants for the y_seq_ctrl sequencer.
//   state_t  : sequencer states
//   iclass_t : instruction class produced by the decoder
//   OP_*     : legal major opcodes
//   ALU_*    : ALU op encodings driven on 'op'
//   WB_*     : write-back source encodings driven on 'wbSel'
package y_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OPW    = 3;
  localparam int unsigned WBW    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_I,
    CL_LD,
    CL_ST,
    CL_BEQ,
    CL_JAL
  } iclass_t;

  localparam logic [6:0] OP_R   = 7'h33;
  localparam logic [6:0] OP_I   = 7'h13;
  localparam logic [6:0] OP_LD  = 7'h03;
  localparam logic [6:0] OP_ST  = 7'h23;
  localparam logic [6:0] OP_BEQ = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F;

  localparam logic [OPW-1:0] ALU_ADD = 3'b010;
  localparam logic [OPW-1:0] ALU_SUB = 3'b110;
  localparam logic [OPW-1:0] ALU_AND = 3'b000;
  localparam logic [OPW-1:0] ALU_OR  = 3'b001;
  localparam logic [OPW-1:0] ALU_SLT = 3'b111;

  localparam logic [WBW-1:0] WB_ALU = 2'b00;
  localparam logic [WBW-1:0] WB_MEM = 2'b01;
  localparam logic [WBW-1:0] WB_PC4 = 2'b10;

  // funct3 -> {legal, alu op}; sub selects subtract for funct3 000.
  function automatic logic [OPW:0] alu_f3(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return {1'b1, (sub ? ALU_SUB : ALU_ADD)};
      3'b111:  return {1'b1, ALU_AND};
      3'b110:  return {1'b1, ALU_OR};
      3'b010:  return {1'b1, ALU_SLT};
      default: return {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/y_ctrl_decode.sv
// Combinational instruction decoder for y_seq_ctrl.
//   ir     in  32  latched instruction register
//   legal  out 1   opcode/funct3 combination is supported
//   alusrc out 1   ALU B operand is the immediate
//   op     out 3   ALU operation
//   wbsel  out 2   write-back source
//   cls    out 3   instruction class, steers the sequencer path
module y_ctrl_decode
  import y_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] ir,
  output logic            legal,
  output logic            alusrc,
  output logic [OPW-1:0]  op,
  output logic [WBW-1:0]  wbsel,
  output iclass_t         cls
);

  logic [OPW:0] f3_dec;
  logic         unused_ir;

  // Only opcode, funct3 and funct7[5] matter to control.
  assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

  // R-type honours funct7[5] for sub; I-type never subtracts.
  assign f3_dec = alu_f3(ir[14:12], (ir[6:0] == OP_R) && ir[30]);

  always_comb begin
    legal  = 1'b0;
    alusrc = 1'b1;
    op     = ALU_ADD;
    wbsel  = WB_ALU;
    cls    = CL_R;
    case (ir[6:0])
      OP_R: begin
        cls    = CL_R;
        alusrc = 1'b0;
        legal  = f3_dec[OPW];
        op     = f3_dec[OPW-1:0];
      end
      OP_I: begin
        cls   = CL_I;
        legal = f3_dec[OPW];
        op    = f3_dec[OPW-1:0];
      end
      OP_LD: begin
        cls   = CL_LD;
        legal = 1'b1;
        wbsel = WB_MEM;
      end
      OP_ST: begin
        cls   = CL_ST;
        legal = 1'b1;
      end
      OP_BEQ: begin
        cls    = CL_BEQ;
        legal  = 1'b1;
        alusrc = 1'b0;
        op     = ALU_SUB;
      end
      OP_JAL: begin
        cls   = CL_JAL;
        legal = 1'b1;
        wbsel = WB_PC4;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/y_seq_ctrl.sv
// Multi-cycle sequencer for the yIF/yID/yEX/yDM/yWB datapath.
// Owns the PC, latches the fetched instruction and drives per-state controls.
//   clk, reset                         clock, synchronous active-high reset
//   run                                start permit, sampled in IDLE
//   ins, zero, PCp4, branch, jTarget   datapath inputs
//   PCin                               PC register to yIF
//   RegWrite, ALUSrc, MemRead, MemWrite, op, wbSel   registered controls
//   halted, illegal, retired           status
module y_seq_ctrl
  import y_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h28,
  parameter int unsigned MAX_INS  = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [XLEN-1:0] ins,
  input  logic            zero,
  input  logic [XLEN-1:0] PCp4,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] jTarget,
  output logic [XLEN-1:0] PCin,
  output logic            RegWrite,
  output logic            ALUSrc,
  output logic            MemRead,
  output logic            MemWrite,
  output logic [OPW-1:0]  op,
  output logic [WBW-1:0]  wbSel,
  output logic            halted,
  output logic            illegal,
  output logic [XLEN-1:0] retired
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] ir_q;

  logic            dec_legal, dec_alusrc;
  logic [OPW-1:0]  dec_op;
  logic [WBW-1:0]  dec_wbsel;
  iclass_t         dec_cls;

  logic            final_c;
  logic            budget_hit_c;
  logic [XLEN-1:0] pc_next_c;

  logic            regwrite_d, alusrc_d, memread_d, memwrite_d, halted_d;
  logic [OPW-1:0]  op_d;
  logic [WBW-1:0]  wbsel_d;

  y_ctrl_decode u_decode (
    .ir     (ir_q),
    .legal  (dec_legal),
    .alusrc (dec_alusrc),
    .op     (dec_op),
    .wbsel  (dec_wbsel),
    .cls    (dec_cls)
  );

  // Retire budget uses the pre-increment count.
  assign budget_hit_c = (MAX_INS != 0) && ((retired + 32'd1) == 32'(MAX_INS));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state, retire strobe and next PC.
  always_comb begin
    state_d   = state_q;
    final_c   = 1'b0;
    pc_next_c = PCp4;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        case (dec_cls)
          CL_LD, CL_ST: state_d = ST_MEM;
          CL_BEQ:       final_c = 1'b1;
          default:      state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (dec_cls == CL_LD) state_d = ST_WB;
        else                  final_c = 1'b1;
      end
      ST_WB:   final_c = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (final_c) state_d = budget_hit_c ? ST_HALT : ST_IDLE;
    if (dec_cls == CL_BEQ)      pc_next_c = zero ? branch : PCp4;
    else if (dec_cls == CL_JAL) pc_next_c = jTarget;
  end

  // Controls for the state being entered; registered below.
  always_comb begin
    regwrite_d = 1'b0;
    alusrc_d   = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    op_d       = '0;
    wbsel_d    = '0;
    halted_d   = (state_d == ST_HALT);
    if (state_d == ST_EXEC || state_d == ST_MEM || state_d == ST_WB) begin
      alusrc_d = dec_alusrc;
      op_d     = dec_op;
    end
    if (state_d == ST_MEM) begin
      memread_d  = (dec_cls == CL_LD);
      memwrite_d = (dec_cls == CL_ST);
    end
    if (state_d == ST_WB) begin
      regwrite_d = 1'b1;
      wbsel_d    = dec_wbsel;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite <= 1'b0;
      ALUSrc   <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      op       <= '0;
      wbSel    <= '0;
      halted   <= 1'b0;
    end else begin
      RegWrite <= regwrite_d;
      ALUSrc   <= alusrc_d;
      MemRead  <= memread_d;
      MemWrite <= memwrite_d;
      op       <= op_d;
      wbSel    <= wbsel_d;
      halted   <= halted_d;
    end
  end

  // IR, PC, retire counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= '0;
      PCin    <= RESET_PC;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      if (state_q == ST_FETCH) ir_q <= ins;
      if (final_c) begin
        PCin    <= pc_next_c;
        retired <= retired + 32'd1;
      end
      if (state_q == ST_DECODE && !dec_legal) illegal <= 1'b1;
    end
  end

endmodule
